// File: rtl/vga_pkg.sv
// Shared VGA timing, memory geometry and pixel helpers for the frame reader and the placer.
package vga_pkg;

    localparam int unsigned H_VIS   = 640;
    localparam int unsigned H_FP    = 16;
    localparam int unsigned H_SYNC  = 96;
    localparam int unsigned H_BP    = 48;
    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_VIS   = 480;
    localparam int unsigned V_FP    = 10;
    localparam int unsigned V_SYNC  = 2;
    localparam int unsigned V_BP    = 33;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int unsigned PIX_W   = 6;
    localparam int unsigned VMEM_AW = 19;
    localparam int unsigned CNT_W   = 10;
    localparam int unsigned CH_W    = 8;
    localparam int unsigned MM_W    = 16;

    localparam logic [MM_W-1:0] STAT_ADDR_DEFAULT = 16'hC008;

    typedef enum logic [1:0] {
        RGN_ACTIVE  = 2'd0,
        RGN_H_BLANK = 2'd1,
        RGN_V_BLANK = 2'd2
    } region_e;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb_t;

    // Replicate a 2-bit channel to full 8-bit swing (00->00, 11->FF).
    function automatic logic [CH_W-1:0] expand2(input logic [1:0] c);
        return {4{c}};
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters, raw sync/visible decode and the start-of-vertical-blank pulse.
module vga_timing_gen #(
    parameter int unsigned H_VIS  = vga_pkg::H_VIS,
    parameter int unsigned H_FP   = vga_pkg::H_FP,
    parameter int unsigned H_SYNC = vga_pkg::H_SYNC,
    parameter int unsigned H_BP   = vga_pkg::H_BP,
    parameter int unsigned V_VIS  = vga_pkg::V_VIS,
    parameter int unsigned V_FP   = vga_pkg::V_FP,
    parameter int unsigned V_SYNC = vga_pkg::V_SYNC,
    parameter int unsigned V_BP   = vga_pkg::V_BP
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pix_en,
    output logic [vga_pkg::CNT_W-1:0] hcnt,
    output logic [vga_pkg::CNT_W-1:0] vcnt,
    output logic                      visible_c,
    output logic                      hsync_raw_c,
    output logic                      vsync_raw_c,
    output logic                      frame_end_c,
    output logic                      vblank_irq
);
    import vga_pkg::*;

    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] H_END    = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_END    = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_STOP  = CNT_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_STOP  = CNT_W'(V_VIS + V_FP + V_SYNC);

    region_e region_c;
    logic    h_wrap_c;

    // Raster region is a pure function of the counters; vertical blank dominates.
    always_comb begin
        region_c = RGN_ACTIVE;
        if (vcnt >= V_VIS_C) begin
            region_c = RGN_V_BLANK;
        end else if (hcnt >= H_VIS_C) begin
            region_c = RGN_H_BLANK;
        end
    end

    assign visible_c   = (region_c == RGN_ACTIVE);
    assign hsync_raw_c = !((hcnt >= HS_START) && (hcnt < HS_STOP));
    assign vsync_raw_c = !((vcnt >= VS_START) && (vcnt < VS_STOP));
    assign h_wrap_c    = (hcnt == H_END);
    assign frame_end_c = h_wrap_c && (vcnt == V_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt       <= '0;
            vcnt       <= '0;
            vblank_irq <= 1'b0;
        end else begin
            vblank_irq <= pix_en && (hcnt == '0) && (vcnt == V_VIS_C);
            if (pix_en) begin
                if (h_wrap_c) begin
                    hcnt <= '0;
                    vcnt <= (vcnt == V_END) ? '0 : vcnt + 1'b1;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vga_frame_reader.sv
// Raster-order video memory reader: read address generation, latency-matched sync/blank,
// colour expansion and a CPU-visible raster status register.
module vga_frame_reader #(
    parameter int unsigned           RD_LATENCY = 1,
    parameter logic [vga_pkg::MM_W-1:0] STAT_ADDR = vga_pkg::STAT_ADDR_DEFAULT,
    parameter int unsigned           H_VIS      = vga_pkg::H_VIS,
    parameter int unsigned           H_FP       = vga_pkg::H_FP,
    parameter int unsigned           H_SYNC     = vga_pkg::H_SYNC,
    parameter int unsigned           H_BP       = vga_pkg::H_BP,
    parameter int unsigned           V_VIS      = vga_pkg::V_VIS,
    parameter int unsigned           V_FP       = vga_pkg::V_FP,
    parameter int unsigned           V_SYNC     = vga_pkg::V_SYNC,
    parameter int unsigned           V_BP       = vga_pkg::V_BP
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pix_en,
    output logic [vga_pkg::VMEM_AW-1:0] raddr,
    output logic                        re,
    input  logic [vga_pkg::PIX_W-1:0]   rdata,
    output logic [vga_pkg::CH_W-1:0]    vga_r,
    output logic [vga_pkg::CH_W-1:0]    vga_g,
    output logic [vga_pkg::CH_W-1:0]    vga_b,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        blank_n,
    output logic                        vblank_irq,
    input  logic [vga_pkg::MM_W-1:0]    mm_addr,
    input  logic                        mm_re,
    output logic [vga_pkg::MM_W-1:0]    mm_rdata
);
    import vga_pkg::*;

    localparam int unsigned LAST = RD_LATENCY - 1;

    logic [CNT_W-1:0]      hcnt;
    logic [CNT_W-1:0]      vcnt;
    logic                  visible_c;
    logic                  hsync_raw_c;
    logic                  vsync_raw_c;
    logic                  frame_end_c;
    logic [RD_LATENCY-1:0] vis_d;
    logic [RD_LATENCY-1:0] hs_d;
    logic [RD_LATENCY-1:0] vs_d;
    rgb_t                  pix_q;

    vga_timing_gen #(
        .H_VIS  (H_VIS),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_VIS  (V_VIS),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_en      (pix_en),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .visible_c   (visible_c),
        .hsync_raw_c (hsync_raw_c),
        .vsync_raw_c (vsync_raw_c),
        .frame_end_c (frame_end_c),
        .vblank_irq  (vblank_irq)
    );

    assign re = visible_c && pix_en;

    // Incrementing on every visible read keeps raddr == vcnt*H_VIS + hcnt without a multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr <= '0;
        end else if (pix_en) begin
            if (frame_end_c) begin
                raddr <= '0;
            end else if (visible_c) begin
                raddr <= raddr + 1'b1;
            end
        end
    end

    // Delay line shifts every clock so the taps line up with the memory's fixed read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vis_d <= '0;
            hs_d  <= '1;
            vs_d  <= '1;
        end else begin
            vis_d <= RD_LATENCY'({vis_d, visible_c});
            hs_d  <= RD_LATENCY'({hs_d, hsync_raw_c});
            vs_d  <= RD_LATENCY'({vs_d, vsync_raw_c});
        end
    end

    // Colour and sync leave together; rdata is only looked at inside the visible window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q   <= '0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            blank_n <= 1'b0;
        end else if (pix_en) begin
            hsync   <= hs_d[LAST];
            vsync   <= vs_d[LAST];
            blank_n <= vis_d[LAST];
            if (vis_d[LAST]) begin
                pix_q.r <= expand2(rdata[5:4]);
                pix_q.g <= expand2(rdata[3:2]);
                pix_q.b <= expand2(rdata[1:0]);
            end else begin
                pix_q <= '0;
            end
        end
    end

    assign vga_r = pix_q.r;
    assign vga_g = pix_q.g;
    assign vga_b = pix_q.b;

    // Side-effect-free status: {in_vblank, hblank, 4'h0, vcnt}.
    always_comb begin
        mm_rdata = '0;
        if (mm_re && (mm_addr == STAT_ADDR)) begin
            mm_rdata = {(vcnt >= CNT_W'(V_VIS)), (hcnt >= CNT_W'(H_VIS)), 4'h0, vcnt};
        end
    end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: full-timing instance (latency 1) and a shrunk-timing instance (latency 2).
module tb_vga_frame_reader;

    localparam int unsigned LAT_F = 1;
    localparam int unsigned LAT_S = 2;
    localparam int unsigned SHV = 16, SHF = 2, SHS = 4, SHB = 3;
    localparam int unsigned SVV = 12, SVF = 2, SVS = 1, SVB = 2;
    localparam logic [15:0] STAT = 16'hC008;

    typedef struct {
        int ht; int hv; int hs0; int hs1;
        int vt; int vv; int vs0; int vs1;
        int lat;
    } geom_t;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       bl;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } vout_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b0;
    logic [15:0] mm_addr = '0;
    logic        mm_re = 1'b0;

    logic [18:0] f_raddr, s_raddr;
    logic        f_re, s_re;
    logic [5:0]  f_rdata, s_rdata;
    logic [7:0]  f_r, f_g, f_b, s_r, s_g, s_b;
    logic        f_hs, f_vs, f_bl, f_irq, s_hs, s_vs, s_bl, s_irq;
    logic [15:0] f_mm, s_mm;
    vout_t       f_obs, s_obs;

    logic [5:0]  f_key = '0;
    logic [5:0]  s_key = '0;
    logic        x_mode = 1'b0;
    geom_t       gf, gs;
    int          checks = 0;
    int          failures = 0;

    assign f_obs = {f_hs, f_vs, f_bl, f_r, f_g, f_b};
    assign s_obs = {s_hs, s_vs, s_bl, s_r, s_g, s_b};

    always #5 clk = ~clk;

    vga_frame_reader #(.RD_LATENCY(LAT_F)) u_full (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .raddr(f_raddr), .re(f_re), .rdata(f_rdata),
        .vga_r(f_r), .vga_g(f_g), .vga_b(f_b),
        .hsync(f_hs), .vsync(f_vs), .blank_n(f_bl), .vblank_irq(f_irq),
        .mm_addr(mm_addr), .mm_re(mm_re), .mm_rdata(f_mm)
    );

    vga_frame_reader #(
        .RD_LATENCY(LAT_S),
        .H_VIS(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_VIS(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .raddr(s_raddr), .re(s_re), .rdata(s_rdata),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
        .hsync(s_hs), .vsync(s_vs), .blank_n(s_bl), .vblank_irq(s_irq),
        .mm_addr(mm_addr), .mm_re(mm_re), .mm_rdata(s_mm)
    );

    // Memory models: a read issued with re returns its data LAT clocks later, otherwise rdata holds (or is X).
    logic [18:0] f_ap [LAT_F];
    logic        f_vp [LAT_F];
    logic [18:0] s_ap [LAT_S];
    logic        s_vp [LAT_S];
    logic [5:0]  f_hold, s_hold;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT_F; i++) begin f_ap[i] <= '0; f_vp[i] <= 1'b0; end
            for (int i = 0; i < LAT_S; i++) begin s_ap[i] <= '0; s_vp[i] <= 1'b0; end
            f_hold <= '0;
            s_hold <= '0;
        end else begin
            f_ap[0] <= f_raddr; f_vp[0] <= f_re;
            s_ap[0] <= s_raddr; s_vp[0] <= s_re;
            for (int i = 1; i < LAT_F; i++) begin f_ap[i] <= f_ap[i-1]; f_vp[i] <= f_vp[i-1]; end
            for (int i = 1; i < LAT_S; i++) begin s_ap[i] <= s_ap[i-1]; s_vp[i] <= s_vp[i-1]; end
            f_hold <= f_rdata;
            s_hold <= s_rdata;
        end
    end

    assign f_rdata = f_vp[LAT_F-1] ? (f_ap[LAT_F-1][5:0] ^ f_key) : f_hold;
    assign s_rdata = s_vp[LAT_S-1] ? (x_mode ? 6'h3F : (s_ap[LAT_S-1][5:0] ^ s_key))
                                   : (x_mode ? 6'bxxxxxx : s_hold);

    // Reference: with pix_en high every clock since reset, cycle k holds pixel k in the
    // counters and shows pixel k-lat-1 on the registered outputs.
    function automatic vout_t exp_out(input geom_t g, input int k, input logic [5:0] key, input logic xm);
        vout_t o;
        int idx, x, y;
        logic [18:0] a;
        logic [5:0] d;
        o = '{hs: 1'b1, vs: 1'b1, bl: 1'b0, r: 8'h00, g: 8'h00, b: 8'h00};
        idx = k - g.lat - 1;
        if (idx >= 0) begin
            x = idx % g.ht;
            y = (idx / g.ht) % g.vt;
            a = 19'(y * g.hv + x);
            d = xm ? 6'h3F : (a[5:0] ^ key);
            o.hs = !(x >= g.hs0 && x < g.hs1);
            o.vs = !(y >= g.vs0 && y < g.vs1);
            o.bl = (x < g.hv && y < g.vv);
            if (o.bl) begin
                o.r = {4{d[5:4]}};
                o.g = {4{d[3:2]}};
                o.b = {4{d[1:0]}};
            end
        end
        return o;
    endfunction

    function automatic logic exp_vis(input geom_t g, input int k);
        return ((k % g.ht) < g.hv) && (((k / g.ht) % g.vt) < g.vv);
    endfunction

    function automatic logic [18:0] exp_addr(input geom_t g, input int k);
        return 19'(((k / g.ht) % g.vt) * g.hv + (k % g.ht));
    endfunction

    function automatic logic exp_irq(input geom_t g, input int k);
        int p;
        p = k - 1;
        if (p < 0) return 1'b0;
        return ((p % g.ht) == 0) && (((p / g.ht) % g.vt) == g.vv);
    endfunction

    function automatic logic [15:0] exp_stat(input geom_t g, input int k, input logic [15:0] a, input logic m);
        int x, y;
        x = k % g.ht;
        y = (k / g.ht) % g.vt;
        if (!(m && a == STAT)) return 16'h0000;
        return {(y >= g.vv), (x >= g.hv), 4'h0, 10'(y)};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        pix_en = 1'b0;
        mm_re = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pix_en = 1'b0;
        mm_re = 1'b1;
        mm_addr = STAT;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (f_raddr !== 19'd0) begin failures++; $display("FAIL reset_raddr got=%0d want=0", f_raddr); end
        checks++; if (f_re !== 1'b0) begin failures++; $display("FAIL reset_re got=%b want=0", f_re); end
        checks++; if (f_hs !== 1'b1) begin failures++; $display("FAIL reset_hsync got=%b want=1", f_hs); end
        checks++; if (f_vs !== 1'b1) begin failures++; $display("FAIL reset_vsync got=%b want=1", f_vs); end
        checks++; if (f_bl !== 1'b0) begin failures++; $display("FAIL reset_blank_n got=%b want=0", f_bl); end
        checks++; if ({f_r, f_g, f_b} !== 24'h0) begin failures++; $display("FAIL reset_rgb got=%h want=000000", {f_r, f_g, f_b}); end
        checks++; if (f_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b want=0", f_irq); end
        checks++; if (f_mm !== 16'h0000) begin failures++; $display("FAIL reset_status got=%h want=0000", f_mm); end
    endtask

    task automatic test_raster();
        int bad_f = 0, bad_s = 0;
        string msg_f = "", msg_s = "";
        vout_t ef, es;
        logic [15:0] stf, sts;
        f_key = 6'h00;
        s_key = 6'($urandom);
        x_mode = 1'b0;
        do_reset();
        pix_en = 1'b1;
        mm_re = 1'b1;
        mm_addr = STAT;
        #1;
        checks++; if (f_re !== 1'b1 || f_raddr !== 19'd0) begin
            failures++; $display("FAIL first_read got re=%b raddr=%0d want re=1 raddr=0", f_re, f_raddr);
        end
        for (int k = 1; k <= 1700; k++) begin
            @(posedge clk);
            #1;
            ef = exp_out(gf, k, f_key, 1'b0);
            es = exp_out(gs, k, s_key, 1'b0);
            stf = exp_stat(gf, k, mm_addr, mm_re);
            sts = exp_stat(gs, k, mm_addr, mm_re);
            if (f_obs !== ef || f_irq !== exp_irq(gf, k) || f_mm !== stf || f_re !== exp_vis(gf, k)
                || (exp_vis(gf, k) && f_raddr !== exp_addr(gf, k))) begin
                if (bad_f == 0) msg_f = $sformatf("k=%0d out=%h/%h irq=%b mm=%h/%h re=%b raddr=%0d/%0d",
                    k, f_obs, ef, f_irq, f_mm, stf, f_re, f_raddr, exp_addr(gf, k));
                bad_f++;
            end
            if (s_obs !== es || s_irq !== exp_irq(gs, k) || s_mm !== sts || s_re !== exp_vis(gs, k)
                || (exp_vis(gs, k) && s_raddr !== exp_addr(gs, k))) begin
                if (bad_s == 0) msg_s = $sformatf("k=%0d out=%h/%h irq=%b mm=%h/%h re=%b raddr=%0d/%0d",
                    k, s_obs, es, s_irq, s_mm, sts, s_re, s_raddr, exp_addr(gs, k));
                bad_s++;
            end
            if (k == 2) begin
                checks++; if (f_bl !== 1'b1 || {f_r, f_g, f_b} !== 24'h0) begin
                    failures++; $display("FAIL pixel_0_0 got blank_n=%b rgb=%h want blank_n=1 rgb=000000", f_bl, {f_r, f_g, f_b});
                end
            end
            if (k == 5) begin
                checks++; if (f_b !== 8'hFF || f_r !== 8'h00 || f_bl !== 1'b1) begin
                    failures++; $display("FAIL pixel_3_0 got r=%h b=%h blank_n=%b want r=00 b=ff blank_n=1", f_r, f_b, f_bl);
                end
            end
            if (k == 639) begin
                checks++; if (f_raddr !== 19'd639) begin failures++; $display("FAIL raddr_639 got=%0d want=639", f_raddr); end
            end
            if (k == 800) begin
                checks++; if (f_raddr !== 19'd640) begin failures++; $display("FAIL raddr_line1 got=%0d want=640", f_raddr); end
            end
            if (k == 128) begin
                checks++; if (s_mm !== 16'h0005) begin failures++; $display("FAIL status_active got=%h want=0005", s_mm); end
            end
            if (k == 145) begin
                checks++; if (s_mm !== 16'h4005) begin failures++; $display("FAIL status_hblank got=%h want=4005", s_mm); end
            end
            if (k == 345) begin
                checks++; if (s_mm !== 16'hC00D) begin failures++; $display("FAIL status_vblank got=%h want=c00d", s_mm); end
            end
            if (k == 200) begin
                checks++; if (s_mm !== 16'h0000) begin failures++; $display("FAIL status_other_addr got=%h want=0000", s_mm); end
            end
            if (k + 1 == 128 || k + 1 == 145 || k + 1 == 345) begin
                mm_re = 1'b1; mm_addr = STAT;
            end else if (k + 1 == 200) begin
                mm_re = 1'b1; mm_addr = STAT + 16'd4;
            end else begin
                mm_re = 1'($urandom);
                mm_addr = ($urandom_range(0, 3) == 0) ? 16'($urandom) : STAT;
            end
        end
        checks++; if (bad_f !== 0) begin failures++; $display("FAIL raster_full mismatches=%0d want=0 first: %s", bad_f, msg_f); end
        checks++; if (bad_s !== 0) begin failures++; $display("FAIL raster_small mismatches=%0d want=0 first: %s", bad_s, msg_s); end
    endtask

    // Counts over two frames of pix_en ticks, after a one-frame warm-up.
    task automatic test_counts(input int period);
        int ft, hs_lo = 0, vs_lo = 0, bl_hi = 0, irqs = 0, bad_hold = 0, ticks = 0, last_irq = -1, gap = -1;
        vout_t prev;
        logic [18:0] praddr;
        ft = gs.ht * gs.vt;
        x_mode = 1'b0;
        do_reset();
        prev = s_obs;
        praddr = s_raddr;
        for (int c = 0; c < 3 * ft * period; c++) begin
            pix_en = ((c % period) == 0);
            @(posedge clk);
            #1;
            if (c >= ft * period) begin
                if (pix_en) begin
                    ticks++;
                    hs_lo += int'(!s_hs);
                    vs_lo += int'(!s_vs);
                    bl_hi += int'(s_bl);
                end else if (s_obs !== prev || s_raddr !== praddr || s_re !== 1'b0) begin
                    bad_hold++;
                end
                if (s_irq) begin
                    irqs++;
                    if (last_irq >= 0) gap = ticks - last_irq;
                    last_irq = ticks;
                end
            end
            prev = s_obs;
            praddr = s_raddr;
        end
        checks++; if (hs_lo !== 2 * gs.vt * (gs.hs1 - gs.hs0)) begin
            failures++; $display("FAIL hsync_low_p%0d got=%0d want=%0d", period, hs_lo, 2 * gs.vt * (gs.hs1 - gs.hs0));
        end
        checks++; if (vs_lo !== 2 * gs.ht * (gs.vs1 - gs.vs0)) begin
            failures++; $display("FAIL vsync_low_p%0d got=%0d want=%0d", period, vs_lo, 2 * gs.ht * (gs.vs1 - gs.vs0));
        end
        checks++; if (bl_hi !== 2 * gs.hv * gs.vv) begin
            failures++; $display("FAIL visible_ticks_p%0d got=%0d want=%0d", period, bl_hi, 2 * gs.hv * gs.vv);
        end
        checks++; if (irqs !== 2) begin failures++; $display("FAIL irq_count_p%0d got=%0d want=2", period, irqs); end
        checks++; if (gap !== ft) begin failures++; $display("FAIL frame_ticks_p%0d got=%0d want=%0d", period, gap, ft); end
        checks++; if (bad_hold !== 0) begin failures++; $display("FAIL hold_p%0d violations=%0d want=0", period, bad_hold); end
    endtask

    task automatic test_xblank();
        int bad = 0, bad_blank = 0;
        string msg = "";
        vout_t es;
        x_mode = 1'b1;
        do_reset();
        pix_en = 1'b1;
        for (int k = 1; k <= 2 * gs.ht * gs.vt; k++) begin
            @(posedge clk);
            #1;
            es = exp_out(gs, k, s_key, 1'b1);
            if (s_obs !== es) begin
                if (bad == 0) msg = $sformatf("k=%0d out=%h want=%h", k, s_obs, es);
                bad++;
            end
            if ($isunknown(s_obs) || (s_bl === 1'b0 && {s_r, s_g, s_b} !== 24'h0)) bad_blank++;
        end
        x_mode = 1'b0;
        checks++; if (bad !== 0) begin failures++; $display("FAIL xblank_stream mismatches=%0d want=0 first: %s", bad, msg); end
        checks++; if (bad_blank !== 0) begin failures++; $display("FAIL xblank_leak cycles=%0d want=0", bad_blank); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        pix_en = 1'b1;
        repeat (700) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (f_raddr !== 19'd0 || f_hs !== 1'b1 || f_bl !== 1'b0) begin
            failures++; $display("FAIL midreset_async got raddr=%0d hsync=%b blank_n=%b want 0/1/0", f_raddr, f_hs, f_bl);
        end
        @(posedge clk);
        #1;
        checks++; if (f_raddr !== 19'd0 || f_hs !== 1'b1) begin
            failures++; $display("FAIL midreset_next_clk got raddr=%0d hsync=%b want 0/1", f_raddr, f_hs);
        end
        rst_n = 1'b1;
        #1;
        checks++; if (f_re !== 1'b1 || f_raddr !== 19'd0) begin
            failures++; $display("FAIL midreset_restart got re=%b raddr=%0d want re=1 raddr=0", f_re, f_raddr);
        end
        @(posedge clk);
        #1;
        checks++; if (f_raddr !== 19'd1) begin failures++; $display("FAIL midreset_advance got=%0d want=1", f_raddr); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        gf = '{ht: 800, hv: 640, hs0: 656, hs1: 752, vt: 525, vv: 480, vs0: 490, vs1: 492, lat: LAT_F};
        gs = '{ht: SHV + SHF + SHS + SHB, hv: SHV, hs0: SHV + SHF, hs1: SHV + SHF + SHS,
               vt: SVV + SVF + SVS + SVB, vv: SVV, vs0: SVV + SVF, vs1: SVV + SVF + SVS, lat: LAT_S};
        test_reset();
        test_raster();
        test_counts(1);
        test_counts(4);
        test_xblank();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
